// File: rtl/bsg_bladerunner_rom_reader_if.sv
// bsg_bladerunner_rom_reader_if: request, ROM-port and response signals of the ROM reader
interface bsg_bladerunner_rom_reader_if #(
    parameter int rom_width_p  = 32,
    parameter int addr_width_p = 4
);
    logic                    req_v_i;
    logic [addr_width_p-1:0] req_addr_i;
    logic                    req_burst_i;
    logic                    req_ready_o;
    logic                    rom_v_o;
    logic [addr_width_p-1:0] rom_addr_o;
    logic [rom_width_p-1:0]  rom_data_i;
    logic                    resp_v_o;
    logic [rom_width_p-1:0]  resp_data_o;
    logic                    resp_err_o;
    logic                    resp_last_o;
    logic                    resp_ready_i;

    modport slave (
        input  req_v_i, req_addr_i, req_burst_i, rom_data_i, resp_ready_i,
        output req_ready_o, rom_v_o, rom_addr_o, resp_v_o, resp_data_o, resp_err_o, resp_last_o
    );

    modport master (
        output req_v_i, req_addr_i, req_burst_i, rom_data_i, resp_ready_i,
        input  req_ready_o, rom_v_o, rom_addr_o, resp_v_o, resp_data_o, resp_err_o, resp_last_o
    );
endinterface

// File: rtl/bsg_bladerunner_rom_reader.sv
// bsg_bladerunner_rom_reader: single/burst ROM read front-end; BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN appends an XOR checksum word to bursts
module bsg_bladerunner_rom_reader #(
    parameter int rom_width_p  = 32,
    parameter int rom_els_p    = 12,
    parameter int addr_width_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    bsg_bladerunner_rom_reader_if.slave bus
);
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, RESP, CHKSUM} state_e;
`else
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, RESP} state_e;
`endif

    localparam logic [addr_width_p:0]   els_lp       = (addr_width_p+1)'(rom_els_p);
    localparam logic [addr_width_p-1:0] last_addr_lp = addr_width_p'(rom_els_p-1);

    state_e                  state_q, state_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic                    burst_q, burst_d;
    logic [rom_width_p-1:0]  data_q, data_d;
    logic                    err_q, err_d;
    logic                    last_q, last_d;
    logic                    final_w;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
    logic [rom_width_p-1:0]  chk_q, chk_d;
`endif

    // Error responses and single reads end after one word; bursts end at the top entry
    assign final_w = err_q | !burst_q | (addr_q == last_addr_lp);

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rom_v_o     = (state_q == FETCH);
    assign bus.rom_addr_o  = addr_q;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
    assign bus.resp_v_o    = (state_q == RESP) | (state_q == CHKSUM);
`else
    assign bus.resp_v_o    = (state_q == RESP);
`endif
    assign bus.resp_data_o = data_q;
    assign bus.resp_err_o  = err_q;
    assign bus.resp_last_o = last_q;

    // Next-state and datapath updates for the request/fetch/capture/respond sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_v_i) begin
                    addr_d = bus.req_addr_i;
                    data_d = '0;
                    err_d  = 1'b0;
                    last_d = 1'b0;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
                    chk_d  = '0;
`endif
                    if ({1'b0, bus.req_addr_i} >= els_lp) begin
                        burst_d = 1'b0;
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        burst_d = bus.req_burst_i;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: state_d = CAPTURE;
            CAPTURE: begin
                data_d  = bus.rom_data_i;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
                last_d  = !burst_q;
                chk_d   = chk_q ^ bus.rom_data_i;
`else
                last_d  = !burst_q | (addr_q == last_addr_lp);
`endif
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    if (final_w) begin
                        state_d = IDLE;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
                        if (burst_q) begin
                            data_d  = chk_q;
                            err_d   = 1'b0;
                            last_d  = 1'b1;
                            state_d = CHKSUM;
                        end
`endif
                    end else begin
                        addr_d  = addr_q + addr_width_p'(1);
                        state_d = FETCH;
                    end
                end
            end
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
            CHKSUM: state_d = bus.resp_ready_i ? IDLE : CHKSUM;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction immediately
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            burst_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            err_q   <= err_d;
            last_q  <= last_d;
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
endmodule

// File: tb/tb_bsg_bladerunner_rom_reader.sv
// tb_bsg_bladerunner_rom_reader: scoreboard bench for the ROM reader with a synchronous ROM model
module tb_bsg_bladerunner_rom_reader;
    localparam int W = 32;
    localparam int N = 12;
    localparam int A = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
        logic         l;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bsg_bladerunner_rom_reader_if #(.rom_width_p(W), .addr_width_p(A)) bus ();

    bsg_bladerunner_rom_reader #(.rom_width_p(W), .rom_els_p(N), .addr_width_p(A)) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    logic [W-1:0] rom [N];
    always @(posedge clk) bus.rom_data_i <= bus.rom_v_o ? rom[bus.rom_addr_o] : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [A-1:0] rq[$];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic push_txn(input int addr, input bit burst);
        logic [W-1:0] acc;
        int top;
        if (addr >= N) sb.push_back({32'h0, 1'b1, 1'b1});
        else begin
            acc = '0;
            top = burst ? N - 1 : addr;
            for (int a = addr; a <= top; a++) begin
                acc ^= rom[a];
                rq.push_back(A'(a));
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
                sb.push_back({rom[a], 1'b0, !burst});
`else
                sb.push_back({rom[a], 1'b0, a == top});
`endif
            end
`ifdef BSG_BLADERUNNER_ROM_READER_CHECKSUM_EN
            if (burst) sb.push_back({acc, 1'b0, 1'b1});
`endif
        end
    endtask

    task automatic issue(input int addr, input bit burst, input int lat_exp);
        int lat;
        push_txn(addr, burst);
        check("req_ready_before_issue", 32'(bus.req_ready_o), 1);
        bus.req_v_i = 1'b1;
        bus.req_addr_i = A'(addr);
        bus.req_burst_i = burst;
        @(posedge clk); #1;
        bus.req_v_i = 1'b0;
        lat = 1;
        while (!bus.resp_v_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(lat_exp));
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while ((!bus.req_ready_o || sb.size() != 0) && n < budget) begin
            bus.resp_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        bus.resp_ready_i = 1'b1;
        check("idle_within_budget", 32'(n < budget), 1);
    endtask

    task automatic check_cleared();
        check("rst_req_ready", 32'(bus.req_ready_o), 1);
        check("rst_resp_v", 32'(bus.resp_v_o), 0);
        check("rst_rom_v", 32'(bus.rom_v_o), 0);
        check("rst_rom_addr", 32'(bus.rom_addr_o), 0);
        check("rst_resp_data", bus.resp_data_o, 0);
        check("rst_err_last", 32'({bus.resp_err_o, bus.resp_last_o}), 0);
    endtask

    // Monitor: ROM-port addresses and response handshakes against the queues, plus stall stability
    initial begin
        exp_t e;
        logic ps;
        logic [W-1:0] pd;
        logic [1:0] pel;
        ps = 1'b0;
        pd = '0;
        pel = '0;
        forever begin
            @(negedge clk);
            if (reset) ps = 1'b0;
            else begin
                if (ps) begin
                    check("stall_valid", 32'(bus.resp_v_o), 1);
                    check("stall_data", bus.resp_data_o, pd);
                    check("stall_err_last", 32'({bus.resp_err_o, bus.resp_last_o}), 32'(pel));
                end
                if (bus.rom_v_o) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rom_v_unexpected: got rom_v_o=1 addr=%0d expected no ROM access", bus.rom_addr_o);
                    end else check("rom_addr", 32'(bus.rom_addr_o), 32'(rq.pop_front()));
                end
                if (bus.resp_v_o && bus.resp_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got data=%0h expected no response", bus.resp_data_o);
                    end else begin
                        e = sb.pop_front();
                        check("resp_data", bus.resp_data_o, e.d);
                        check("resp_err", 32'(bus.resp_err_o), 32'(e.e));
                        check("resp_last", 32'(bus.resp_last_o), 32'(e.l));
                    end
                end
                ps = bus.resp_v_o && !bus.resp_ready_i;
                pd = bus.resp_data_o;
                pel = {bus.resp_err_o, bus.resp_last_o};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int g;
        int n;
        for (int i = 0; i < N; i++) rom[i] = 32'h100 + W'(i);
        rom[0] = 32'h0000_0C0D;
        bus.req_v_i = 1'b0;
        bus.req_addr_i = '0;
        bus.req_burst_i = 1'b0;
        bus.resp_ready_i = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared();
        reset = 1'b0;
        @(posedge clk); #1;

        issue(0, 1'b0, 3);
        @(posedge clk); #1;
        check("req_ready_after_single", 32'(bus.req_ready_o), 1);
        wait_idle(50, 1'b0);

        issue(12, 1'b0, 1);
        wait_idle(50, 1'b0);
        issue(15, 1'b1, 1);
        wait_idle(50, 1'b0);

        issue(9, 1'b1, 3);
        for (int k = 0; k < 2; k++) begin
            g = 0;
            do begin
                @(posedge clk); #1;
                g++;
            end while (!bus.resp_v_o && g < 20);
            check("burst_spacing", 32'(g), 3);
        end
        wait_idle(50, 1'b0);

        issue(0, 1'b1, 3);
        wait_idle(400, 1'b1);

        issue(0, 1'b1, 3);
        n = 0;
        while (!(bus.rom_v_o && bus.rom_addr_o == 4'd5) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_fetch_addr5", 32'(n < 50), 1);
        bus.resp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("resp_at_addr5", 32'({bus.resp_v_o, bus.rom_addr_o}), 32'({1'b1, 4'd5}));
        #2;
        reset = 1'b1;
        sb.delete();
        rq.delete();
        #1;
        check_cleared();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.resp_ready_i = 1'b1;
        issue(2, 1'b0, 3);
        wait_idle(50, 1'b0);

        rom[10] = 32'hA5A5_0000;
        rom[11] = 32'h0000_5A5A;
        issue(10, 1'b1, 3);
        wait_idle(50, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("rom_q_drained", 32'(rq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
